// File: rtl/ram_walk_pkg.sv
// ============================================================================
// Module  : ram_walk_pkg
// Brief   : Shared types and constants for the RAM walk master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_walk_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CHECK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_walk_if.sv
// ============================================================================
// Module  : ram_walk_if
// Brief   : Avalon-MM s1 port bundle between the walk master and the RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_walk_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m_address;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_clken;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

`default_nettype wire

// File: rtl/ram_walk_pattern_gen.sv
// ============================================================================
// Module  : ram_walk_pattern_gen
// Brief   : Expected-word generator: current word plus a copy aligned to read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_walk_pattern_gen
    import ram_walk_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic [DATA_W-1:0] seed,
    input  wire logic              incr,
    input  wire logic              issue,
    input  wire logic [ADDR_W:0]   idx,
    output logic      [DATA_W-1:0] exp_cur,
    output logic      [DATA_W-1:0] exp_dly
);

    logic [DATA_W-1:0] seed_q, seed_d;
    logic              incr_q, incr_d;
    logic [DATA_W-1:0] exp_cur_q, exp_cur_d;
    logic [DATA_W-1:0] exp_dly_q, exp_dly_d;
    logic [DATA_W-1:0] next_exp;

    always_comb begin
        seed_d = seed_q;
        incr_d = incr_q;
        if (load) begin
            seed_d = seed;
            incr_d = incr;
        end
        // Word 0 is issued in the same cycle the seed is captured.
        if (load)
            next_exp = seed;
        else if (incr_q)
            next_exp = seed_q + DATA_W'(idx);
        else
            next_exp = seed_q;
        exp_cur_d = issue ? next_exp : exp_cur_q;
        exp_dly_d = exp_cur_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seed_q    <= '0;
            incr_q    <= 1'b0;
            exp_cur_q <= '0;
            exp_dly_q <= '0;
        end else begin
            seed_q    <= seed_d;
            incr_q    <= incr_d;
            exp_cur_q <= exp_cur_d;
            exp_dly_q <= exp_dly_d;
        end
    end

    assign exp_cur = exp_cur_q;
    assign exp_dly = exp_dly_q;

endmodule

`default_nettype wire

// File: rtl/ram_walk_master.sv
// ============================================================================
// Module  : ram_walk_master
// Brief   : Fills or checks a word range of the on-chip RAM with a seed pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_walk_master
    import ram_walk_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              cmd_start,
    input  wire logic              cmd_op,
    input  wire logic              cmd_incr,
    input  wire logic [ADDR_W-1:0] cmd_base,
    input  wire logic [ADDR_W:0]   cmd_len,
    input  wire logic [DATA_W-1:0] cmd_pattern,
    output logic                   cmd_busy,
    output logic                   cmd_done,
    output logic      [ADDR_W:0]   err_count,
    output logic      [ADDR_W-1:0] err_first_addr,
    output logic                   err_seen,
    ram_walk_if.master             m
);

    localparam logic [ADDR_W:0] C_ERR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_ONE     = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              rd_vld_q, rd_vld_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_first_q, err_first_d;
    logic              err_seen_q, err_seen_d;
    logic              load;
    logic              issue;
    logic [DATA_W-1:0] exp_cur;
    logic [DATA_W-1:0] exp_dly;

    ram_walk_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .seed    (cmd_pattern),
        .incr    (cmd_incr),
        .issue   (issue),
        .idx     (idx_q),
        .exp_cur (exp_cur),
        .exp_dly (exp_dly)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        base_d      = base_q;
        addr_d      = addr_q;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        rd_vld_d    = 1'b0;
        done_d      = 1'b0;
        load        = 1'b0;
        issue       = 1'b0;
        cmp_vld_d   = rd_vld_q;
        cmp_addr_d  = addr_q;
        err_count_d = err_count_q;
        err_first_d = err_first_q;
        err_seen_d  = err_seen_q;

        // Read data for the address on the bus last cycle arrives now.
        if (cmp_vld_q && (m.m_readdata != exp_dly)) begin
            if (err_count_q != C_ERR_MAX)
                err_count_d = err_count_q + C_ONE;
            if (!err_seen_q) begin
                err_first_d = cmp_addr_q;
                err_seen_d  = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    load   = 1'b1;
                    base_d = cmd_base;
                    len_d  = cmd_len;
                    idx_d  = C_ONE;
                    if (cmd_op == OP_CHECK) begin
                        err_count_d = '0;
                        err_first_d = '0;
                        err_seen_d  = 1'b0;
                    end
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        issue    = 1'b1;
                        cs_d     = 1'b1;
                        wr_d     = (cmd_op == OP_FILL);
                        rd_vld_d = (cmd_op == OP_CHECK);
                        addr_d   = cmd_base;
                        state_d  = (cmd_op == OP_FILL) ? ST_FILL : ST_READ;
                    end
                end
            end
            ST_FILL, ST_READ: begin
                if (idx_q == len_q) begin
                    if (state_q == ST_FILL) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    issue    = 1'b1;
                    cs_d     = 1'b1;
                    wr_d     = (state_q == ST_FILL);
                    rd_vld_d = (state_q == ST_READ);
                    addr_d   = base_q + idx_q[ADDR_W-1:0];
                    idx_d    = idx_q + C_ONE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            cmp_addr_q  <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            cmp_vld_q   <= 1'b0;
            err_count_q <= '0;
            err_first_q <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            cmp_addr_q  <= cmp_addr_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            cmp_vld_q   <= cmp_vld_d;
            err_count_q <= err_count_d;
            err_first_q <= err_first_d;
            err_seen_q  <= err_seen_d;
        end
    end

    // Strobes are masked by reset so a mid-command abort issues no write in the reset cycle.
    assign m.m_chipselect  = cs_q & ~reset;
    assign m.m_write       = wr_q & ~reset;
    assign m.m_address     = addr_q;
    assign m.m_writedata   = exp_cur;
    assign m.m_byteenable  = {BE_W{1'b1}};
    assign m.m_clken       = 1'b1;

    assign cmd_busy        = (state_q != ST_IDLE);
    assign cmd_done        = done_q;
    assign err_count       = err_count_q;
    assign err_first_addr  = err_first_q;
    assign err_seen        = err_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_walk_master.sv
// ============================================================================
// Module  : tb_ram_walk_master
// Brief   : Self-checking bench with a RAM slave and a behavioural reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_walk_master;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start, cmd_op, cmd_incr;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] cmd_pattern;
    logic          cmd_busy, cmd_done, err_seen;
    logic [AW:0]   err_count;
    logic [AW-1:0] err_first_addr;

    int tests = 0;
    int fails = 0;

    ram_walk_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_walk_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_op         (cmd_op),
        .cmd_incr       (cmd_incr),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .cmd_pattern    (cmd_pattern),
        .cmd_busy       (cmd_busy),
        .cmd_done       (cmd_done),
        .err_count      (err_count),
        .err_first_addr (err_first_addr),
        .err_seen       (err_seen),
        .m              (bus)
    );

    always #5 clk = ~clk;

    // RAM slave: registered read, no waitrequest; bench may plant a corrupt word.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] corrupt_data = '0;

    always @(posedge clk) begin
        if (corrupt_en)
            mem[corrupt_addr] <= corrupt_data;
        else if (bus.m_chipselect && bus.m_write)
            mem[bus.m_address] <= bus.m_writedata;
        bus.m_readdata <= mem[bus.m_address];
    end

    // Bus monitor
    logic [AW+DW-1:0] wq[$];
    int cs_cnt = 0;
    int proto_bad = 0;
    always @(posedge clk) begin
        if (bus.m_chipselect) cs_cnt++;
        if (bus.m_chipselect && bus.m_write) wq.push_back({bus.m_address, bus.m_writedata});
        if (bus.m_write && !bus.m_chipselect) proto_bad++;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            m_err_count = 0;
    int            m_err_first = 0;
    bit            m_err_seen  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_err_count"}, 64'(err_count), 64'(m_err_count));
        check({tag, "_err_seen"}, 64'(err_seen), 64'(m_err_seen));
        if (m_err_seen)
            check({tag, "_err_first"}, 64'(err_first_addr), 64'(m_err_first));
    endtask

    task automatic corrupt(input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        corrupt_en   = 1'b1;
        corrupt_addr = AW'(addr);
        corrupt_data = data;
        @(negedge clk);
        corrupt_en   = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic run_cmd(input logic op, input logic incr, input int base, input int len,
                           input logic [DW-1:0] pat, input bit poke);
        int            exp_lat, lat, a;
        logic [DW-1:0] e;
        logic [AW+DW-1:0] exp_wq[$];

        exp_lat = (len == 0) ? 1 : (op ? len + 2 : len + 1);
        for (int i = 0; i < len; i++) begin
            a = (base + i) % DEPTH;
            e = pat + (incr ? DW'(i) : '0);
            if (!op) begin
                exp_wq.push_back({AW'(a), e});
                ref_mem[a] = e;
            end
        end
        if (op) begin
            m_err_count = 0;
            m_err_seen  = 1'b0;
            m_err_first = 0;
            for (int i = 0; i < len; i++) begin
                a = (base + i) % DEPTH;
                e = pat + (incr ? DW'(i) : '0);
                if (ref_mem[a] !== e) begin
                    if (m_err_count < DEPTH) m_err_count++;
                    if (!m_err_seen) begin
                        m_err_seen  = 1'b1;
                        m_err_first = a;
                    end
                end
            end
        end

        @(negedge clk);
        wq.delete();
        cs_cnt      = 0;
        cmd_op      = op;
        cmd_incr    = incr;
        cmd_base    = AW'(base);
        cmd_len     = (AW+1)'(len);
        cmd_pattern = pat;
        cmd_start   = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        lat = 1;
        check("busy_after_accept", 64'(cmd_busy), 64'(1));
        while (!cmd_done && lat < 5000) begin
            if (poke && lat == 2) begin
                cmd_start   = 1'b1;
                cmd_op      = ~op;
                cmd_base    = AW'(base + 7);
                cmd_len     = (AW+1)'(3);
                cmd_pattern = ~pat;
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        cmd_start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("byteenable", 64'(bus.m_byteenable), 64'hF);
        check("clken", 64'(bus.m_clken), 64'(1));
        @(negedge clk);
        check("done_one_cycle", 64'(cmd_done), 64'(0));
        check("idle_after_done", 64'(cmd_busy), 64'(0));
        check("cs_cycles", 64'(cs_cnt), 64'(len));
        check("write_count", 64'(wq.size()), 64'(exp_wq.size()));
        for (int k = 0; k < exp_wq.size() && k < wq.size(); k++)
            check("write_addr_data", 64'(wq[k]), 64'(exp_wq[k]));
        check_errs(op ? "check" : "fill");
    endtask

    initial begin
        int b, l, op, inc, ca;
        logic [DW-1:0] p;
        int last_b, last_l, last_inc;
        logic [DW-1:0] last_p;

        reset = 1'b1; cmd_start = 1'b0; cmd_op = 1'b0; cmd_incr = 1'b0;
        cmd_base = '0; cmd_len = '0; cmd_pattern = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(cmd_busy), 64'(0));
        check("rst_done", 64'(cmd_done), 64'(0));
        check("rst_cs", 64'(bus.m_chipselect), 64'(0));
        check("rst_write", 64'(bus.m_write), 64'(0));
        check("rst_addr", 64'(bus.m_address), 64'(0));
        check("rst_wdata", 64'(bus.m_writedata), 64'(0));
        check("rst_errcnt", 64'(err_count), 64'(0));
        check("rst_errfirst", 64'(err_first_addr), 64'(0));
        check("rst_errseen", 64'(err_seen), 64'(0));
        check("rst_be", 64'(bus.m_byteenable), 64'hF);
        check("rst_clken", 64'(bus.m_clken), 64'(1));
        reset = 1'b0;

        // Whole-RAM fill whose pattern wraps at 32 bits, then whole-RAM check.
        run_cmd(1'b0, 1'b1, 0, DEPTH, 32'hFFFF_FF00, 1'b0);
        run_cmd(1'b1, 1'b1, 0, DEPTH, 32'hFFFF_FF00, 1'b0);

        run_cmd(1'b0, 1'b1, 0, 4, 32'hA5A5_0000, 1'b0);
        run_cmd(1'b1, 1'b1, 0, 4, 32'hA5A5_0000, 1'b0);
        corrupt(2, 32'h0);
        run_cmd(1'b1, 1'b1, 0, 4, 32'hA5A5_0000, 1'b0);
        run_cmd(1'b0, 1'b0, 2046, 4, 32'hDEAD_BEEF, 1'b0);
        check("addr2_untouched", 64'(mem[2]), 64'(0));
        run_cmd(1'b0, 1'b0, 300, 0, 32'h1234_5678, 1'b0);
        run_cmd(1'b1, 1'b0, 300, 0, 32'h1234_5678, 1'b0);
        run_cmd(1'b0, 1'b1, 500, 6, 32'h0BAD_F00D, 1'b1);
        run_cmd(1'b1, 1'b1, 500, 6, 32'h0BAD_F00D, 1'b1);

        last_b = 0; last_l = 4; last_inc = 1; last_p = 32'hA5A5_0000;
        for (int it = 0; it < 24; it++) begin
            op  = int'($urandom_range(0, 1));
            inc = int'($urandom_range(0, 1));
            b   = int'($urandom_range(0, DEPTH - 1));
            l   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH)) : int'($urandom_range(0, 24));
            p   = $urandom;
            if (op == 1 && $urandom_range(0, 2) != 0) begin
                b = last_b; l = last_l; inc = last_inc; p = last_p;
                if (l > 0 && $urandom_range(0, 1) == 1) begin
                    ca = (b + int'($urandom_range(0, l - 1))) % DEPTH;
                    corrupt(ca, $urandom);
                end
            end
            if (op == 0) begin
                last_b = b; last_l = l; last_inc = inc; last_p = p;
            end
            run_cmd(op[0], inc[0], b, l, p, 1'b0);
        end

        // Reset lands in the third FILL cycle: exactly two words reach the RAM.
        @(negedge clk);
        wq.delete();
        cmd_op = 1'b0; cmd_incr = 1'b1; cmd_base = AW'(100); cmd_len = (AW+1)'(8);
        cmd_pattern = 32'h5555_0000; cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(cmd_busy), 64'(0));
        check("abort_done", 64'(cmd_done), 64'(0));
        check("abort_cs", 64'(bus.m_chipselect), 64'(0));
        check("abort_write", 64'(bus.m_write), 64'(0));
        check("abort_addr", 64'(bus.m_address), 64'(0));
        check("abort_wdata", 64'(bus.m_writedata), 64'(0));
        check("abort_errcnt", 64'(err_count), 64'(0));
        check("abort_errseen", 64'(err_seen), 64'(0));
        check("abort_writes", 64'(wq.size()), 64'(2));
        if (wq.size() >= 2) begin
            check("abort_w0", 64'(wq[0]), 64'({AW'(100), 32'h5555_0000}));
            check("abort_w1", 64'(wq[1]), 64'({AW'(101), 32'h5555_0001}));
        end
        ref_mem[100] = 32'h5555_0000;
        ref_mem[101] = 32'h5555_0001;
        m_err_count = 0; m_err_seen = 1'b0; m_err_first = 0;
        reset = 1'b0;
        @(negedge clk);
        run_cmd(1'b1, 1'b1, 100, 8, 32'h5555_0000, 1'b0);
        run_cmd(1'b0, 1'b1, 100, 8, 32'h5555_0000, 1'b0);
        run_cmd(1'b1, 1'b1, 100, 8, 32'h5555_0000, 1'b0);

        check("write_without_cs", 64'(proto_bad), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_walk_master.md
Name: ram_walk_master

Overview:
- Avalon-MM master that drives the s1 port of the 2048x32 on-chip RAM slave in the alarm_clk system.
- Used for boot-time fill, RAM self-test and testbench preload/readback.
- A single command either fills a contiguous word range with a constant or incrementing pattern, or reads the range back and compares it against the same pattern, counting mismatches.
- The block sits between the control logic (or testbench) and the RAM; the RAM has no waitrequest and returns read data one clock after the address.

Parameters:
- ADDR_W, 11, word-address width; depth = 2**ADDR_W.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byteenable width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle command strobe; accepted only when cmd_busy=0.
- cmd_op  in  1  0=FILL, 1=CHECK.
- cmd_incr  in  1  0=constant pattern, 1=pattern+index.
- cmd_base  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W+1  number of words, 0..2**ADDR_W.
- cmd_pattern  in  DATA_W  seed pattern.
- cmd_busy  out  1  high from the cycle after acceptance until done.
- cmd_done  out  1  one-cycle pulse at completion.
- err_count  out  ADDR_W+1  mismatches from the last CHECK.
- err_first_addr  out  ADDR_W  address of the first mismatch.
- err_seen  out  1  at least one mismatch in the last CHECK.
- m_address  out  ADDR_W  RAM word address.
- m_byteenable  out  BE_W  always all ones.
- m_chipselect  out  1  access strobe.
- m_write  out  1  write qualifier.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  RAM read data, valid one cycle after address.
- m_clken  out  1  RAM clock enable; constant 1.

Behaviour:
- Reset state (synchronous, active-high): state=IDLE; cmd_busy=0, cmd_done=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, err_count=0, err_first_addr=0, err_seen=0. m_byteenable=all ones; m_clken=1.
- Reset asserted mid-operation aborts the command on the next edge. No m_write is issued in the reset cycle or after it. Error results are cleared.
- States: IDLE, FILL, READ, DRAIN, DONE.
- IDLE:
  - cmd_start=1 latches all cmd_* inputs.
  - Index i is set to 0; error registers are cleared if op=CHECK.
  - cmd_len=0 -> DONE. Otherwise op=FILL -> FILL, op=CHECK -> READ.
  - cmd_start while busy is ignored.
- FILL: each cycle drives chipselect=1, write=1, address=(base+i) mod 2**ADDR_W, writedata=expected(i), then i++. After issuing word len-1 -> DONE. Throughput is 1 word/clk, so the cycles spent in FILL equal len.
- READ: each cycle drives chipselect=1, write=0, address=(base+i) mod depth. A compare-valid flag and the expected value are pipelined one stage. After issuing the last word -> DRAIN.
- DRAIN: one cycle with chipselect=0; compares the final returned word, then -> DONE.
- Compare: happens in the cycle after an address is issued. If m_readdata != expected:
  - err_count++, saturating at 2**ADDR_W.
  - If err_seen=0: err_first_addr=that address and err_seen=1.
- expected(i) = cmd_pattern when incr=0. When incr=1 it is (cmd_pattern + i) mod 2**DATA_W, so it wraps at 32 bits.
- DONE: cmd_done=1 for exactly one cycle, chipselect=0, -> IDLE.
- cmd_busy=1 in FILL/READ/DRAIN/DONE and 0 in IDLE.
- Latency from start to done pulse: FILL = len+1 cycles; CHECK = len+2 cycles; len=0 gives 1 cycle.
- Address wrap: base+i wraps modulo depth. Example: base=2046, len=4 accesses 2046, 2047, 0, 1.
- len = depth covers every word exactly once.
- Error outputs hold until the next accepted CHECK or reset; a FILL does not clear them.
- Outside FILL/READ: m_write=0 and m_chipselect=0. m_write is never asserted without m_chipselect.

Decomposition:
- Shared package ram_walk_pkg:
  - state enum (IDLE, FILL, READ, DRAIN, DONE);
  - op encoding constants OP_FILL=0, OP_CHECK=1;
  - default ADDR_W/DATA_W localparams.
- One natural sub-module, ram_walk_pattern_gen: holds seed/incr and produces expected(i) plus a one-stage delayed copy for the compare. Everything else stays flat.

Test Plan:
- FILL base=0, len=4, pattern=0xA5A5_0000, incr=1 -> writes 0xA5A50000..0xA5A50003 to addresses 0..3 on consecutive cycles; done 5 cycles after start; byteenable=0xF.
- CHECK of the same range after that fill -> err_count=0, err_seen=0, done 6 cycles after start.
- Bench corrupts address 2 to 0 then runs CHECK base=0, len=4 -> err_count=1, err_first_addr=2, err_seen=1.
- FILL base=2046, len=4, constant 0xDEAD_BEEF -> writes go to 2046, 2047, 0, 1 only; address 2 is untouched.
- Edge cases:
  - len=0 -> no chipselect, done 1 cycle after start.
  - cmd_start pulsed while busy -> ignored.
  - len=2048 CHECK on a fully filled RAM -> err_count=0.
- Reset asserted on the 3rd cycle of FILL len=8 -> only 2 writes observed, outputs return to reset values, next command runs normally.
